// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the keyboard clock,
// deserializes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// and folds F0/E0 prefix bytes into a 16-bit scan code.
module ps2_keyboard_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic        newchar,
   output logic [15:0] char,
   output logic        frame_err,
   output logic        busy
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic           clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
   logic           filt_level_q, filt_level_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           fall_q, fall_d;

   state_t         state_q;
   logic [2:0]     bit_cnt_q;
   logic [7:0]     shift_q;
   logic           parity_q;
   logic [7:0]     prefix_q;
   logic [TCW-1:0] to_cnt_q;
   logic           newchar_q, frame_err_q;
   logic [15:0]    char_q;

   // Two-flop synchronizers on both raw keyboard lines.
   always_ff @(posedge clk) begin
      // NOTE: PS/2 lines idle high, so the synchronizers reset to 1 to avoid
      // manufacturing a falling edge right after reset.
      if (reset) begin
         clk_s1_q  <= 1'b1;
         clk_s2_q  <= 1'b1;
         data_s1_q <= 1'b1;
         data_s2_q <= 1'b1;
      end else begin
         clk_s1_q  <= ps2_clk;
         clk_s2_q  <= clk_s1_q;
         data_s1_q <= ps2_data;
         data_s2_q <= data_s1_q;
      end
   end

   // Deglitch filter: accept a new clock level after FILTER_LEN differing samples.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      filt_level_d = filt_level_q;
      filt_cnt_d   = '0;
      fall_d       = 1'b0;
      if (clk_s2_q != filt_level_q) begin
         if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
            filt_level_d = clk_s2_q;
            fall_d       = ~clk_s2_q;
         end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
         end
      end
   end

   // Filter state and the one-cycle falling-edge flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt_level_q <= 1'b1;
         filt_cnt_q   <= '0;
         fall_q       <= 1'b0;
      end else begin
         filt_level_q <= filt_level_d;
         filt_cnt_q   <= filt_cnt_d;
         fall_q       <= fall_d;
      end
   end

   // Frame FSM with timeout, prefix tracking and registered output pulses.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments throughout so every register sees the
      // values from before this edge, regardless of statement order.
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         prefix_q    <= 8'h00;
         to_cnt_q    <= '0;
         newchar_q   <= 1'b0;
         frame_err_q <= 1'b0;
         char_q      <= 16'h0000;
      end else begin
         newchar_q   <= 1'b0;
         frame_err_q <= 1'b0;
         if (state_q == IDLE) begin
            to_cnt_q <= '0;
            if (fall_q && !data_s2_q) begin
               state_q   <= DATA;
               bit_cnt_q <= '0;
            end
         end else if (fall_q) begin
            to_cnt_q <= '0;
            case (state_q)
               DATA: begin
                  shift_q   <= {data_s2_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= PARITY;
               end
               PARITY: begin
                  parity_q <= data_s2_q;
                  state_q  <= STOP;
               end
               default: begin
                  state_q <= IDLE;
                  if (data_s2_q && (^{shift_q, parity_q})) begin
                     if (shift_q == 8'hF0) begin
                        prefix_q <= 8'hF0;
                     end else if (shift_q == 8'hE0) begin
                        // A pending break prefix is not displaced by E0.
                        prefix_q <= (prefix_q == 8'hF0) ? 8'hF0 : 8'hE0;
                     end else begin
                        char_q    <= {prefix_q, shift_q};
                        newchar_q <= 1'b1;
                        prefix_q  <= 8'h00;
                     end
                  end else begin
                     frame_err_q <= 1'b1;
                     prefix_q    <= 8'h00;
                  end
               end
            endcase
         end else if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the partial frame silently; the pending prefix survives.
            state_q  <= IDLE;
            to_cnt_q <= '0;
         end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
      end
   end

   assign newchar   = newchar_q;
   assign frame_err = frame_err_q;
   assign char      = char_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized samples required before a ps2_clk level change is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: number of clk cycles without an accepted ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-006 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-007 newchar  output  1  one-cycle pulse marking that char carries a newly completed scan code.
REQ-008 char  output  16  completed scan code: {prefix byte, code byte}; prefix is 8'h00, 8'hF0 or 8'hE0.
REQ-009 frame_err  output  1  one-cycle pulse marking a discarded frame (bad parity or bad stop bit).
REQ-010 busy  output  1  high while a frame is in progress (state other than IDLE).

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 The synchronized ps2_clk SHALL be deglitched: the filtered level changes only after FILTER_LEN consecutive equal samples; a falling edge is the filtered level going 1->0, flagged for exactly one clk cycle.
REQ-013 ps2_data SHALL be sampled (synchronized value) in the cycle the filtered falling edge is flagged.
REQ-014 FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a falling edge with data=0 (start bit), go to DATA and clear bit counter; with data=1, stay in IDLE, no output.
REQ-016 DATA: on each falling edge, shift data into an 8-bit register LSB first; after the 8th bit go to PARITY.
REQ-017 PARITY: on a falling edge, capture the parity bit and go to STOP.
REQ-018 STOP: on a falling edge, return to IDLE; the frame is valid only if the 8 data bits plus the parity bit contain an odd number of ones and the stop bit is 1.
REQ-019 Valid byte 8'hF0 or 8'hE0: no newchar; the byte is stored as pending prefix (F0 overrides a pending E0; E0 followed by F0 leaves prefix F0 with the E0 dropped).
REQ-020 Any other valid byte: char <= {pending prefix or 8'h00, byte}, newchar pulses high for exactly the cycle after the stop-bit edge, and the pending prefix clears.
REQ-021 char SHALL hold its value between pulses; it changes only together with a newchar pulse.
REQ-022 Invalid frame: frame_err pulses for one cycle in the same cycle newchar would have pulsed; the byte is discarded; the pending prefix clears; char is unchanged.
REQ-023 Timeout counter SHALL clear on every accepted falling edge and in IDLE; reaching TIMEOUT_CYCLES in any state other than IDLE returns the FSM to IDLE, discards the partial frame, and asserts neither newchar nor frame_err; the pending prefix is kept.
REQ-024 newchar and frame_err SHALL never be high in the same cycle.
REQ-025 At most one FSM transition occurs per accepted falling edge; ps2 activity while newchar is high SHALL be processed normally, with no edge lost.

Reset
REQ-026 With reset high at a clk edge: state=IDLE, bit counter=0, shift register=0, pending prefix=8'h00, timeout counter=0, filter level=1, synchronizers=1, newchar=0, frame_err=0, busy=0, char=16'h0000.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no output pulse; the first frame after release decodes normally.

Verification
REQ-028 Frame for byte 8'h1C (parity 0, stop 1) -> one newchar pulse, char=16'h001C, frame_err stays 0, busy falls in the same cycle.
REQ-029 Frames 8'hF0 then 8'h1C -> exactly one newchar pulse, after the second frame, with char=16'hF01C; a following 8'h32 frame -> char=16'h0032.
REQ-030 Frames 8'hE0 then 8'h75 -> a single newchar, char=16'hE075.
REQ-031 Frame 8'h1C with the parity bit flipped -> frame_err pulses once, no newchar, char keeps its prior value; a following valid 8'h1C frame -> char=16'h001C.
REQ-032 Start bit plus 4 data bits, then ps2_clk held high for more than TIMEOUT_CYCLES -> busy returns to 0 with no pulses; a following 8'h32 frame -> char=16'h0032.
REQ-033 Glitches on ps2_clk shorter than FILTER_LEN cycles during a valid 8'h1C frame -> decoded char=16'h001C unchanged; reset pulse in the DATA state -> no pulse, busy=0 in the next cycle.
